clmul_unit: RTL and testbench

Iterative carry-less multiplier for the Zbc instructions (clmul, clmulh, clmulr) in the execute stage. It sits next to the combinational bit-manipulation unit and takes the same operand pair from operand select. The execute result mux then picks its result in place of the bit-manipulation result for CLMUL-class functions. It processes BITS_PER_CYCLE bits of op2 per clock under a start/valid handshake, and the pipeline stalls execute while it is busy.

---
 rtl/clmul_unit_if.sv | 34 +++
 rtl/clmul_unit.sv | 119 +++++++++++
 tb/tb_clmul_unit.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/clmul_unit_if.sv
// Operand/handshake bundle between operand select, the execute stage and clmul_unit.
// The unit takes the slave side; the execute-stage driver takes the master side.
interface clmul_unit_if;
  logic        s_flush_i;
  logic        s_start_i;
  logic [1:0]  s_function_i;
  logic [31:0] s_op1_i;
  logic [31:0] s_op2_i;
  logic        s_busy_o;
  logic        s_valid_o;
  logic [31:0] s_result_o;

  modport master (
    output s_flush_i,
    output s_start_i,
    output s_function_i,
    output s_op1_i,
    output s_op2_i,
    input  s_busy_o,
    input  s_valid_o,
    input  s_result_o
  );

  modport slave (
    input  s_flush_i,
    input  s_start_i,
    input  s_function_i,
    input  s_op1_i,
    input  s_op2_i,
    output s_busy_o,
    output s_valid_o,
    output s_result_o
  );
endinterface

// File: rtl/clmul_unit.sv
// Iterative carry-less multiplier for clmul / clmulh / clmulr.
// Consumes BITS_PER_CYCLE multiplier bits per cycle; every output is driven from a flop.
module clmul_unit #(
  parameter int BITS_PER_CYCLE = 4
) (
  input  logic        s_clk_i,
  input  logic        s_resetn_i,
  clmul_unit_if.slave bus
);

  localparam int N  = 32 / BITS_PER_CYCLE;
  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_reg;
  logic [63:0]   op1_reg;
  logic [31:0]   op2_reg;
  logic [63:0]   acc_reg;
  logic [63:0]   acc_next;
  logic [1:0]    func_reg;
  logic [CW-1:0] cnt_reg;
  logic [31:0]   result_reg;
  logic [31:0]   result_next;
  logic          busy_reg;
  logic          valid_reg;

  // One shifted copy of the multiplicand per multiplier bit handled this cycle.
  logic [63:0] term [BITS_PER_CYCLE];

  genvar gi;
  generate
    for (gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_term
      assign term[gi] = op2_reg[gi] ? (op1_reg << gi) : 64'h0;
    end
  endgenerate

  always_comb begin
    acc_next = acc_reg;
    for (int j = 0; j < BITS_PER_CYCLE; j++) begin
      acc_next = acc_next ^ term[j];
    end
  end

  // Result is taken from acc_next so the last partial products land in the same edge.
  always_comb begin
    result_next = 32'h0;
    case (func_reg)
      2'b00:   result_next = acc_next[31:0];
      2'b01:   result_next = acc_next[63:32];
      2'b10:   result_next = acc_next[62:31];
      default: result_next = 32'h0;
    endcase
  end

  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i) begin
      state_reg  <= IDLE;
      op1_reg    <= 64'h0;
      op2_reg    <= 32'h0;
      acc_reg    <= 64'h0;
      func_reg   <= 2'b00;
      cnt_reg    <= '0;
      result_reg <= 32'h0;
      busy_reg   <= 1'b0;
      valid_reg  <= 1'b0;
    end else if (bus.s_flush_i) begin
      // Flush beats start; result_reg deliberately keeps its last value.
      state_reg <= IDLE;
      busy_reg  <= 1'b0;
      valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (bus.s_start_i) begin
            state_reg <= RUN;
            op1_reg   <= {32'h0, bus.s_op1_i};
            op2_reg   <= bus.s_op2_i;
            func_reg  <= bus.s_function_i;
            acc_reg   <= 64'h0;
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
            valid_reg <= 1'b0;
          end else begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
            valid_reg <= 1'b0;
          end
        end
        RUN: begin
          acc_reg <= acc_next;
          op1_reg <= op1_reg << BITS_PER_CYCLE;
          op2_reg <= op2_reg >> BITS_PER_CYCLE;
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == CW'(N - 1)) begin
            state_reg  <= DONE;
            result_reg <= result_next;
            busy_reg   <= 1'b0;
            valid_reg  <= 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.s_busy_o   = busy_reg;
  assign bus.s_valid_o  = valid_reg;
  assign bus.s_result_o = result_reg;

endmodule

// File: tb/tb_clmul_unit.sv
// Scoreboard bench for clmul_unit: expected results are queued at start and
// compared against every valid pulse; timing, flush and reset cases are checked directly.
module tb_clmul_unit;

  localparam int BPC = 4;
  localparam int N   = 32 / BPC;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  clmul_unit_if bus ();

  clmul_unit #(.BITS_PER_CYCLE(BPC)) dut (
    .s_clk_i    (clk),
    .s_resetn_i (rst_n),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", tag, obs, exp);
    end
  endtask

  // Reference product straight from the XOR-of-shifts definition.
  function automatic logic [31:0] clmul_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] fn);
    logic [63:0] p;
    p = 64'h0;
    for (int i = 0; i < 32; i++) begin
      if (b[i]) p = p ^ ({32'h0, a} << i);
    end
    case (fn)
      2'b00:   return p[31:0];
      2'b01:   return p[63:32];
      2'b10:   return p[62:31];
      default: return 32'h0;
    endcase
  endfunction

  // Every valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus.s_valid_o) begin : mon
      logic [31:0] e;
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        $display("txn result=%h expected=%h", bus.s_result_o, e);
        check("result", bus.s_result_o, e);
      end
    end
  end

  // Called at a negedge; holds start for one cycle and returns at the next negedge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [1:0] fn,
                       input bit push, input logic [31:0] e);
    bus.s_start_i    = 1'b1;
    bus.s_op1_i      = a;
    bus.s_op2_i      = b;
    bus.s_function_i = fn;
    if (push) exp_q.push_back(e);
    @(negedge clk);
    bus.s_start_i = 1'b0;
  endtask

  // Walks negedges until valid; lat counts cycles since the accepting edge.
  task automatic wait_valid(input int first, output int lat, output int busy_cnt);
    lat = first;
    busy_cnt = 0;
    while (!bus.s_valid_o && lat <= 40) begin
      if (bus.s_busy_o) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    if (!bus.s_valid_o) check("valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] fn, input logic [31:0] e);
    int lat, bc;
    issue(a, b, fn, 1'b1, e);
    wait_valid(1, lat, bc);
    check({tag, "_latency"}, 32'(lat), 32'(N + 1));
    check({tag, "_direct"}, bus.s_result_o, e);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, bc;
    logic [31:0] a, b, ea, ec;
    logic [1:0]  fn;

    bus.s_start_i    = 1'b0;
    bus.s_flush_i    = 1'b0;
    bus.s_function_i = 2'b00;
    bus.s_op1_i      = 32'h0;
    bus.s_op2_i      = 32'h0;
    repeat (3) @(negedge clk);
    check("reset_busy",   {31'h0, bus.s_busy_o},  32'h0);
    check("reset_valid",  {31'h0, bus.s_valid_o}, 32'h0);
    check("reset_result", bus.s_result_o,         32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic timing: 9-cycle latency, 8 busy cycles, one-cycle valid.
    issue(32'h3, 32'h3, 2'b00, 1'b1, 32'h5);
    wait_valid(1, lat, bc);
    check("t1_latency", 32'(lat), 32'd9);
    check("t1_busy_cycles", 32'(bc), 32'd8);
    check("t1_result", bus.s_result_o, 32'h5);
    @(negedge clk);
    check("t1_valid_width", {31'h0, bus.s_valid_o}, 32'h0);
    check("t1_result_hold", bus.s_result_o, 32'h5);

    run_op("ones_clmul",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 32'h5555_5555);
    run_op("ones_clmulh", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b01, 32'h5555_5555);
    run_op("ones_clmulr", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b10, 32'hAAAA_AAAA);
    run_op("msb_rsvd",    32'h8000_0000, 32'h0000_0002, 2'b11, 32'h0000_0000);
    run_op("msb_clmul",   32'h8000_0000, 32'h0000_0002, 2'b00, 32'h0000_0000);
    run_op("msb_clmulh",  32'h8000_0000, 32'h0000_0002, 2'b01, 32'h0000_0001);
    run_op("msb_clmulr",  32'h8000_0000, 32'h0000_0002, 2'b10, 32'h0000_0002);

    // Flush in the third RUN cycle.
    issue(32'h1234_5678, 32'h9ABC_DEF1, 2'b00, 1'b0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    check("flush_busy_before", {31'h0, bus.s_busy_o}, 32'h1);
    bus.s_flush_i = 1'b1;
    @(negedge clk);
    bus.s_flush_i = 1'b0;
    check("flush_busy", {31'h0, bus.s_busy_o}, 32'h0);
    check("flush_valid", {31'h0, bus.s_valid_o}, 32'h0);
    check("flush_result_kept", bus.s_result_o, 32'h2);
    repeat (N + 2) @(negedge clk);
    check("flush_busy_later", {31'h0, bus.s_busy_o}, 32'h0);

    // Flush together with start in IDLE.
    bus.s_flush_i = 1'b1;
    issue(32'h1234_5678, 32'h0000_00FF, 2'b00, 1'b0, 32'h0);
    bus.s_flush_i = 1'b0;
    check("flush_start_busy", {31'h0, bus.s_busy_o}, 32'h0);
    repeat (N + 2) @(negedge clk);
    check("flush_start_result", bus.s_result_o, 32'h2);

    // Start during RUN is ignored; then a start in the DONE cycle runs back-to-back.
    a  = 32'h1234_5678;
    b  = 32'h0F0F_00FF;
    ea = clmul_ref(a, b, 2'b00);
    issue(a, b, 2'b00, 1'b1, ea);
    @(negedge clk);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b01, 1'b0, 32'h0);
    wait_valid(3, lat, bc);
    check("ignore_latency", 32'(lat), 32'(N + 1));
    check("ignore_result", bus.s_result_o, ea);
    ec = clmul_ref(32'hCAFE_F00D, 32'h8765_4321, 2'b01);
    issue(32'hCAFE_F00D, 32'h8765_4321, 2'b01, 1'b1, ec);
    check("b2b_busy", {31'h0, bus.s_busy_o}, 32'h1);
    wait_valid(1, lat, bc);
    check("b2b_latency", 32'(lat), 32'(N + 1));
    check("b2b_result", bus.s_result_o, ec);
    @(negedge clk);

    // Asynchronous reset mid-RUN.
    issue(32'hDEAD_BEEF, 32'h0000_1234, 2'b10, 1'b1, clmul_ref(32'hDEAD_BEEF, 32'h0000_1234, 2'b10));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_busy", {31'h0, bus.s_busy_o}, 32'h0);
    check("arst_valid", {31'h0, bus.s_valid_o}, 32'h0);
    check("arst_result", bus.s_result_o, 32'h0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (N + 3) @(negedge clk);
    check("arst_idle_busy", {31'h0, bus.s_busy_o}, 32'h0);
    run_op("after_reset", 32'h0000_0007, 32'h0000_0005, 2'b00, 32'h0000_001B);

    // Random operands, all functions.
    for (int k = 0; k < 6; k++) begin
      a  = $urandom;
      b  = $urandom;
      fn = 2'($urandom_range(0, 3));
      run_op("random", a, b, fn, clmul_ref(a, b, fn));
    end

    repeat (2) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
